// File: rtl/spi_regs_pkg.sv
// Shared definitions for the SPI register bank and other SPI byte-interface clients.
// Holds the FSM state encoding and the command byte layout.
package spi_regs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Command byte: bit 7 selects write (1) or read (0), bits 6:0 are the start address.
  localparam int CMD_BIT = 7;
  localparam int ADDR_W  = 7;

  function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] b);
    return b[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector on a level input using a two-flop history register.
// o_rise is high for one cycle when the history reads 2'b01 (older=0, newer=1).
module edge_detect_rise (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic [1:0] r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= 2'b00;
    end else begin
      r_hist <= {r_hist[0], i_level};
    end
  end

  assign o_rise = (r_hist == 2'b01);

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind an SPI slave byte interface: a command byte selects read/write
// and a start address, following bytes burst through an auto-incrementing pointer.
module spi_reg_bank
  import spi_regs_pkg::*;
#(
  parameter int                      NUM_REGS   = 8,
  parameter logic [7:0]              FW_VERSION = 8'hC2,
  parameter logic [NUM_REGS-1:0]     RW_MASK    = NUM_REGS'(8'b0000_0010),
  parameter logic [NUM_REGS*8-1:0]   RESET_VALS = '0
) (
  input  logic                    clk_core,
  input  logic                    reset_n,
  input  logic                    transaction_begin,
  input  logic                    rx_byte_available,
  input  logic [7:0]              rx_byte,
  output logic [7:0]              tx_byte,
  input  logic [NUM_REGS*8-1:0]   reg_in,
  output logic [NUM_REGS*8-1:0]   reg_out,
  output logic [NUM_REGS-1:0]     wr_pulse,
  output logic                    wr_err,
  output state_t                  dbg_state
);

  // Register 0 is always the read-only version byte, whatever RW_MASK says.
  localparam logic [NUM_REGS-1:0] RW_EFF = RW_MASK & ~NUM_REGS'(1);

  state_t              r_state;
  logic                r_cmd;
  logic [ADDR_W-1:0]   r_ptr;
  logic [7:0]          r_tx;
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic                r_wr_err;

  logic                  w_rx_edge;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic [7:0]            w_rd_data;
  logic                  w_ptr_rw;
  logic [NUM_REGS-1:0]   w_wr_vec;
  logic [NUM_REGS*8-1:0] w_reg_q;
  logic                  w_unused_reg_in;

  // The spi_slave holds rx_byte stable while rx_byte_available is high; a new byte is
  // flagged by a 0->1 transition, and no back-pressure exists on this interface.
  edge_detect_rise u_rx_edge (
    .i_clk   (clk_core),
    .i_rst_n (reset_n),
    .i_level (rx_byte_available),
    .o_rise  (w_rx_edge)
  );

  // In CMD the byte being received is itself the address; in DATA the pointer is used.
  always_comb begin
    w_rd_addr = (r_state == ST_CMD) ? cmd_addr(rx_byte) : r_ptr;
  end

  always_comb begin
    w_rd_data = 8'h00;
    w_ptr_rw  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_addr == ADDR_W'(i)) begin
        if (i == 0) begin
          w_rd_data = FW_VERSION;
        end else if (RW_EFF[i]) begin
          w_rd_data = w_reg_q[i*8 +: 8];
        end else begin
          w_rd_data = reg_in[i*8 +: 8];
        end
      end
      if ((r_ptr == ADDR_W'(i)) && RW_EFF[i]) begin
        w_ptr_rw = 1'b1;
      end
    end
  end

  always_comb begin
    w_wr_vec = '0;
    if ((r_state == ST_DATA) && r_cmd && w_rx_edge && !transaction_begin && w_ptr_rw) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        w_wr_vec[i] = (r_ptr == ADDR_W'(i));
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RW_EFF[g]) begin : g_rw
      logic [7:0] r_val;
      always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
          r_val <= RESET_VALS[g*8 +: 8];
        end else if (w_wr_vec[g]) begin
          r_val <= rx_byte;
        end
      end
      assign w_reg_q[g*8 +: 8] = r_val;
    end else begin : g_ro
      assign w_reg_q[g*8 +: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cmd      <= 1'b0;
      r_ptr      <= '0;
      r_tx       <= 8'h00;
      r_wr_pulse <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_pulse <= w_wr_vec;
      if (transaction_begin) begin
        // A new slave-select always wins over a byte arriving in the same cycle.
        r_state <= ST_CMD;
        r_tx    <= 8'h00;
      end else if (w_rx_edge) begin
        case (r_state)
          ST_CMD: begin
            r_cmd   <= rx_byte[CMD_BIT];
            r_state <= ST_DATA;
            if (rx_byte[CMD_BIT]) begin
              r_tx  <= 8'h00;
              r_ptr <= cmd_addr(rx_byte);
            end else begin
              r_tx  <= w_rd_data;
              r_ptr <= cmd_addr(rx_byte) + 1'b1;
            end
          end
          ST_DATA: begin
            r_ptr <= r_ptr + 1'b1;
            if (r_cmd) begin
              if (!w_ptr_rw) begin
                r_wr_err <= 1'b1;
              end
            end else begin
              r_tx <= w_rd_data;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign w_unused_reg_in = ^reg_in;

  assign tx_byte   = r_tx;
  assign reg_out   = w_reg_q;
  assign wr_pulse  = r_wr_pulse;
  assign wr_err    = r_wr_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: 8 registers, only register 1 read/write (reset 8'h3C),
// read-only status bytes 8'h10+i on reg_in.
module tb_spi_reg_bank;
  import spi_regs_pkg::*;

  localparam int NR = 8;

  logic          clk_core = 1'b0;
  logic          reset_n = 1'b0;
  logic          transaction_begin = 1'b0;
  logic          rx_byte_available = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic [7:0]    tx_byte;
  logic [NR*8-1:0] reg_in = 64'h1716_1514_1312_1100;
  logic [NR*8-1:0] reg_out;
  logic [NR-1:0] wr_pulse;
  logic          wr_err;
  state_t        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0]  tx_after2;
  logic [NR-1:0] seen_pulse = '0;
  int          pulse_cycles = 0;
  logic        clr_seen = 1'b0;

  spi_reg_bank #(
    .NUM_REGS   (NR),
    .FW_VERSION (8'hC2),
    .RW_MASK    (8'b0000_0010),
    .RESET_VALS (64'h0000_0000_0000_3C00)
  ) dut (
    .clk_core          (clk_core),
    .reset_n           (reset_n),
    .transaction_begin (transaction_begin),
    .rx_byte_available (rx_byte_available),
    .rx_byte           (rx_byte),
    .tx_byte           (tx_byte),
    .reg_in            (reg_in),
    .reg_out           (reg_out),
    .wr_pulse          (wr_pulse),
    .wr_err            (wr_err),
    .dbg_state         (dbg_state)
  );

  always #10 clk_core = ~clk_core;

  // Accumulates write strobes between clears so pulses between checks are not missed.
  always @(negedge clk_core) begin
    if (clr_seen) begin
      seen_pulse   <= '0;
      pulse_cycles <= 0;
    end else begin
      seen_pulse <= seen_pulse | wr_pulse;
      if (wr_pulse != '0) pulse_cycles <= pulse_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  task automatic clear_seen();
    clr_seen = 1'b1;
    tick(1);
    clr_seen = 1'b0;
  endtask

  task automatic do_begin();
    transaction_begin = 1'b1;
    tick(1);
    transaction_begin = 1'b0;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_byte_available = 1'b1;
    tick(2);
    tx_after2 = tx_byte;
    tick(2);
    rx_byte_available = 1'b0;
    tick(3);
  endtask

  task automatic collide(input logic [7:0] b);
    rx_byte = b;
    rx_byte_available = 1'b1;
    tick(1);
    transaction_begin = 1'b1;
    tick(1);
    transaction_begin = 1'b0;
    tick(2);
    rx_byte_available = 1'b0;
    tick(3);
  endtask

  initial begin
    tick(3);
    check("rst_tx", 64'(tx_byte), 64'h00);
    check("rst_err", 64'(wr_err), 64'h0);
    check("rst_pulse", 64'(wr_pulse), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_regs", reg_out, 64'h0000_0000_0000_3C00);
    reset_n = 1'b1;
    tick(2);

    send_byte(8'h81);
    check("idle_state", 64'(dbg_state), 64'(ST_IDLE));
    check("idle_tx", 64'(tx_byte), 64'h00);

    do_begin();
    check("begin_state", 64'(dbg_state), 64'(ST_CMD));
    check("begin_tx", 64'(tx_byte), 64'h00);
    send_byte(8'h00);
    check("ver_lat2", 64'(tx_after2), 64'hC2);
    check("ver_state", 64'(dbg_state), 64'(ST_DATA));
    send_byte(8'h33);
    check("rd1_rw", 64'(tx_byte), 64'h3C);
    send_byte(8'h33);
    check("rd2_ro", 64'(tx_byte), 64'h12);

    do_begin();
    clear_seen();
    send_byte(8'h81);
    check("wcmd_tx", 64'(tx_byte), 64'h00);
    send_byte(8'h01);
    check("w1_reg", reg_out, 64'h0000_0000_0000_0100);
    check("w1_pulse", 64'(seen_pulse), 64'h02);
    check("w1_pulse_len", 64'(pulse_cycles), 64'd1);
    check("w1_err", 64'(wr_err), 64'h0);
    clear_seen();
    send_byte(8'hAA);
    check("w2_reg", reg_out, 64'h0000_0000_0000_0100);
    check("w2_pulse", 64'(seen_pulse), 64'h00);
    check("w2_err", 64'(wr_err), 64'h1);
    check("w2_tx", 64'(tx_byte), 64'h00);

    do_begin();
    send_byte(8'h07);
    check("rd7", 64'(tx_byte), 64'h17);
    send_byte(8'h00);
    check("rd8_oor", 64'(tx_byte), 64'h00);
    send_byte(8'h00);
    check("rd9_oor", 64'(tx_byte), 64'h00);
    send_byte(8'h00);
    check("rd10_oor", 64'(tx_byte), 64'h00);
    do_begin();
    send_byte(8'h7F);
    check("rd127", 64'(tx_byte), 64'h00);
    send_byte(8'h00);
    check("wrap_rd0", 64'(tx_byte), 64'hC2);
    send_byte(8'h00);
    check("wrap_rd1", 64'(tx_byte), 64'h01);

    do_begin();
    send_byte(8'h81);
    clear_seen();
    collide(8'h5A);
    check("col_state", 64'(dbg_state), 64'(ST_CMD));
    check("col_tx", 64'(tx_byte), 64'h00);
    check("col_pulse", 64'(seen_pulse), 64'h00);
    check("col_reg", reg_out, 64'h0000_0000_0000_0100);
    send_byte(8'h00);
    check("col_cmd_rd", 64'(tx_byte), 64'hC2);

    do_begin();
    send_byte(8'h81);
    clear_seen();
    rx_byte = 8'h99;
    rx_byte_available = 1'b1;
    tick(1);
    reset_n = 1'b0;
    tick(2);
    check("mrst_reg", reg_out, 64'h0000_0000_0000_3C00);
    check("mrst_err", 64'(wr_err), 64'h0);
    check("mrst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mrst_tx", 64'(tx_byte), 64'h00);
    check("mrst_pulse", 64'(seen_pulse), 64'h00);
    reset_n = 1'b1;
    tick(3);
    rx_byte_available = 1'b0;
    tick(3);
    check("post_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("post_rst_reg", reg_out, 64'h0000_0000_0000_3C00);

    do_begin();
    clear_seen();
    send_byte(8'h80);
    check("w0_cmd_tx", 64'(tx_byte), 64'h00);
    send_byte(8'h55);
    check("w0_err", 64'(wr_err), 64'h1);
    check("w0_pulse", 64'(seen_pulse), 64'h00);
    check("w0_regs", reg_out, 64'h0000_0000_0000_3C00);
    do_begin();
    send_byte(8'h00);
    check("w0_readback", 64'(tx_byte), 64'hC2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
